// File: rtl/dffnq_stim_chk.sv
// Stimulus generator and checker for a negedge D flip-flop.
// Drives CLKN/D with programmable period and setup, then scores Q.
module dffnq_stim_chk #(
  parameter int DIV_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [15:0]      PATTERN,
  input  logic [3:0]       LEN,
  input  logic [DIV_W-1:0] DIV,
  input  logic [DIV_W-1:0] SETUP,
  output logic             CLKN_O,
  output logic             D_O,
  input  logic             Q_I,
  output logic             BUSY,
  output logic             DONE,
  output logic [4:0]       ERR_CNT,
  output logic             ERR_VLD,
  output logic [3:0]       FIRST_ERR
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    FIN
  } st_t;

  st_t st, st_n;

  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] div_q, setup_q;
  logic [DIV_W-1:0] div_in, setup_in;
  logic [DIV_W-1:0] p_div, p_setup;
  logic [3:0]       idx, idx_n;
  logic [3:0]       len_q, last;
  logic [15:0]      pat_q, p_pat;
  logic             go, smp, miss, upd;

  assign div_in   = (DIV == '0) ? DIV_W'(1) : DIV;
  assign setup_in = (SETUP > div_in) ? div_in : SETUP;
  assign go       = (st == IDLE) && START;

  // Parameters seen by the update decode: live inputs on the start cycle.
  assign p_div    = go ? div_in   : div_q;
  assign p_setup  = go ? setup_in : setup_q;
  assign p_pat    = go ? PATTERN  : pat_q;

  // LEN=0 wraps to index 15, i.e. 16 bits.
  assign last = len_q - 4'd1;
  assign smp  = (st == LOW) && (cnt == div_q - DIV_W'(1));
  assign miss = smp && (Q_I != pat_q[idx]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      st  <= IDLE;
      cnt <= '0;
      idx <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      idx <= idx_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    idx_n = idx;
    unique case (st)
      IDLE: begin
        if (START) begin
          st_n  = HIGH;
          cnt_n = '0;
          idx_n = '0;
        end
      end
      HIGH: begin
        if (cnt == div_q - DIV_W'(1)) begin
          st_n  = LOW;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      LOW: begin
        if (cnt == div_q - DIV_W'(1)) begin
          cnt_n = '0;
          if (idx == last) begin
            st_n = FIN;
          end else begin
            st_n  = HIGH;
            idx_n = idx + 4'd1;
          end
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      FIN: st_n = IDLE;
    endcase
    // Zero setup moves D together with the CLKN fall.
    upd = ((st_n == HIGH) && (cnt_n == p_div - p_setup))
       || ((st_n == LOW) && (cnt_n == '0) && (p_setup == '0));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CLKN_O    <= 1'b1;
      D_O       <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR_CNT   <= '0;
      ERR_VLD   <= 1'b0;
      FIRST_ERR <= '0;
      div_q     <= DIV_W'(1);
      setup_q   <= '0;
      len_q     <= '0;
      pat_q     <= '0;
    end else begin
      CLKN_O <= (st_n != LOW);
      BUSY   <= (st_n == HIGH) || (st_n == LOW);
      DONE   <= (st_n == FIN);
      if (upd) D_O <= p_pat[idx_n];
      if (go) begin
        div_q     <= div_in;
        setup_q   <= setup_in;
        len_q     <= LEN;
        pat_q     <= PATTERN;
        ERR_CNT   <= '0;
        ERR_VLD   <= 1'b0;
        FIRST_ERR <= '0;
      end else if (miss) begin
        if (ERR_CNT != 5'd16) ERR_CNT <= ERR_CNT + 5'd1;
        if (!ERR_VLD) begin
          ERR_VLD   <= 1'b1;
          FIRST_ERR <= idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_dffnq_stim_chk.sv
// Bench for dffnq_stim_chk: cycle-formula reference model,
// ideal/forced/random Q sources, directed and random runs.
module tb_dffnq_stim_chk;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] PATTERN = '0;
  logic [3:0]  LEN = '0;
  logic [3:0]  DIV = '0;
  logic [3:0]  SETUP = '0;
  logic        CLKN_O, D_O, Q_I, BUSY, DONE, ERR_VLD;
  logic [4:0]  ERR_CNT;
  logic [3:0]  FIRST_ERR;

  int   checks = 0;
  int   errors = 0;
  int   qmode = 0;
  logic rnd = 1'b0;
  logic q_dff = 1'b0;
  logic m_d = 1'b0;
  int   falls[$];
  int   dchg[$];
  int   done_at;
  logic [3:0] trace[0:1023];
  logic [3:0] tsave[0:1023];

  dffnq_stim_chk dut (
    .CLK(CLK), .RST(RST), .START(START), .PATTERN(PATTERN),
    .LEN(LEN), .DIV(DIV), .SETUP(SETUP), .CLKN_O(CLKN_O),
    .D_O(D_O), .Q_I(Q_I), .BUSY(BUSY), .DONE(DONE),
    .ERR_CNT(ERR_CNT), .ERR_VLD(ERR_VLD), .FIRST_ERR(FIRST_ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLKN_O) q_dff <= D_O;

  assign Q_I = (qmode == 0) ? q_dff : ((qmode == 1) ? rnd : 1'b0);

  task automatic run(input logic [15:0] p, input logic [3:0] l,
                     input logic [3:0] dv, input logic [3:0] su,
                     input int qm, input int pulse_at,
                     input string name);
    int D, S, L, T, ec;
    logic [3:0] exp, got;
    logic ev, pc, pd;
    logic [3:0] fe;
    logic qh[0:1023];
    D = (dv == 0) ? 1 : int'(dv);
    S = (int'(su) > D) ? D : int'(su);
    L = (l == 0) ? 16 : int'(l);
    T = 2 * D * L + 1;
    falls.delete();
    dchg.delete();
    done_at = -1;
    qmode = qm;
    PATTERN = p; LEN = l; DIV = dv; SETUP = su;
    START = 1'b1;
    pc = CLKN_O;
    pd = D_O;
    @(posedge CLK);
    #1 START = 1'b0;
    for (int c = 1; c <= T + 1; c++) begin
      @(negedge CLK);
      for (int k = 0; k < L; k++)
        if (c == 2 * D * k + D - S + 1) m_d = p[k];
      if (c == T) exp = {1'b1, m_d, 1'b0, 1'b1};
      else if (c == T + 1) exp = {1'b1, m_d, 2'b00};
      else exp = {((c - 1) % (2 * D)) < D, m_d, 1'b1, 1'b0};
      got = {CLKN_O, D_O, BUSY, DONE};
      trace[c] = got;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d {clkn,d,busy,done} got %b exp %b",
                 name, c, got, exp);
      end
      if (pc && !CLKN_O) falls.push_back(c);
      if (D_O !== pd) dchg.push_back(c);
      if (DONE) done_at = c;
      pc = CLKN_O;
      pd = D_O;
      if (START) START = 1'b0;
      if (c == pulse_at) begin
        START = 1'b1;
        PATTERN = 16'($urandom);
        LEN = 4'($urandom);
        DIV = 4'($urandom);
        SETUP = 4'($urandom);
      end
      rnd = 1'($urandom);
      qh[c] = (qm == 0) ? q_dff : ((qm == 1) ? rnd : 1'b0);
    end
    ec = 0; ev = 1'b0; fe = '0;
    for (int k = 0; k < L; k++)
      if (qh[2 * D * (k + 1)] !== p[k]) begin
        if (!ev) begin ev = 1'b1; fe = 4'(k); end
        ec++;
      end
    checks++;
    if (ERR_CNT !== 5'(ec)) begin
      errors++;
      $display("FAIL %s err_cnt got %0d exp %0d", name, ERR_CNT, ec);
    end
    checks++;
    if (ERR_VLD !== ev) begin
      errors++;
      $display("FAIL %s err_vld got %b exp %b", name, ERR_VLD, ev);
    end
    checks++;
    if (FIRST_ERR !== fe) begin
      errors++;
      $display("FAIL %s first_err got %0d exp %0d", name, FIRST_ERR, fe);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    START = 1'b1;
    PATTERN = 16'hFFFF; LEN = 4'd1; DIV = 4'd1; SETUP = 4'd1;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (CLKN_O !== 1'b1) begin errors++; $display("FAIL rst clkn got %b exp 1", CLKN_O); end
    checks++;
    if (D_O !== 1'b0) begin errors++; $display("FAIL rst d got %b exp 0", D_O); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL rst busy got %b exp 0", BUSY); end
    checks++;
    if (DONE !== 1'b0) begin errors++; $display("FAIL rst done got %b exp 0", DONE); end
    checks++;
    if (ERR_CNT !== 5'd0) begin errors++; $display("FAIL rst err_cnt got %0d exp 0", ERR_CNT); end
    checks++;
    if (ERR_VLD !== 1'b0) begin errors++; $display("FAIL rst err_vld got %b exp 0", ERR_VLD); end
    checks++;
    if (FIRST_ERR !== 4'd0) begin errors++; $display("FAIL rst first_err got %0d exp 0", FIRST_ERR); end
    RST = 1'b0;
    START = 1'b0;
    m_d = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_prio busy got %b exp 0", BUSY); end
  endtask

  task automatic test_basic();
    int ef[4] = '{3, 7, 11, 15};
    int ed[3] = '{6, 10, 14};
    int bad;
    run(16'h000A, 4'd4, 4'd2, 4'd1, 0, 0, "basic");
    bad = (falls.size() != 4) ? 1 : 0;
    if (bad == 0) foreach (ef[k]) if (falls[k] != ef[k]) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_falls got %0d edges first %0d exp 3,7,11,15",
               falls.size(), (falls.size() > 0) ? falls[0] : -1);
    end
    bad = (dchg.size() != 3) ? 1 : 0;
    if (bad == 0) foreach (ed[k]) if (dchg[k] != ed[k]) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_dchg got %0d changes exp 6,10,14", dchg.size());
    end
    checks++;
    if (done_at != 17) begin errors++; $display("FAIL basic_done got %0d exp 17", done_at); end
    checks++;
    if (ERR_CNT !== 5'd0 || ERR_VLD !== 1'b0) begin
      errors++;
      $display("FAIL basic_err got %0d/%b exp 0/0", ERR_CNT, ERR_VLD);
    end
  endtask

  task automatic test_force0();
    run(16'h000A, 4'd4, 4'd2, 4'd1, 2, 0, "force0");
    checks++;
    if (ERR_CNT !== 5'd2 || ERR_VLD !== 1'b1 || FIRST_ERR !== 4'd1) begin
      errors++;
      $display("FAIL force0 got cnt %0d vld %b first %0d exp 2 1 1",
               ERR_CNT, ERR_VLD, FIRST_ERR);
    end
  endtask

  task automatic test_len0_div0();
    int bad;
    run(16'hFFFF, 4'd0, 4'd0, 4'd1, 0, 0, "len0_div0");
    bad = (falls.size() != 16) ? 1 : 0;
    if (bad == 0) foreach (falls[k]) if (falls[k] != 2 * k + 2) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL len0_falls got %0d edges exp 16 at 2,4..32", falls.size());
    end
    checks++;
    if (done_at != 33) begin errors++; $display("FAIL len0_done got %0d exp 33", done_at); end
  endtask

  task automatic test_setup_clamp();
    int n, diff;
    int ed[3] = '{10, 16, 22};
    int bad;
    run(16'h00B5, 4'd8, 4'd3, 4'd9, 0, 0, "clamp9");
    n = 2 * 3 * 8 + 2;
    for (int c = 1; c <= n; c++) tsave[c] = trace[c];
    run(16'h00B5, 4'd8, 4'd3, 4'd3, 0, 0, "clamp3");
    diff = 0;
    for (int c = 1; c <= n; c++) if (tsave[c] !== trace[c]) diff++;
    checks++;
    if (diff != 0) begin
      errors++;
      $display("FAIL clamp_same got %0d differing cycles exp 0", diff);
    end
    run(16'h0005, 4'd4, 4'd3, 4'd0, 2, 0, "setup0");
    bad = (dchg.size() != 3) ? 1 : 0;
    if (bad == 0) foreach (ed[k]) if (dchg[k] != ed[k]) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL setup0_dchg got %0d changes exp 10,16,22", dchg.size());
    end
  endtask

  task automatic test_start_busy();
    run(16'h3C5A, 4'd6, 4'd2, 4'd2, 1, 5, "start_busy");
    run(16'h1234, 4'd5, 4'd1, 4'd1, 1, 11, "start_fin");
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || CLKN_O !== 1'b1) begin
      errors++;
      $display("FAIL start_fin_idle got busy %b clkn %b exp 0 1", BUSY, CLKN_O);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge CLK);
    qmode = 0;
    PATTERN = 16'h000F; LEN = 4'd4; DIV = 4'd2; SETUP = 4'd1;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    for (int c = 1; c <= 11; c++) @(negedge CLK);
    checks++;
    if (CLKN_O !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL rmid_low got clkn %b busy %b exp 0 1", CLKN_O, BUSY);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    m_d = 1'b0;
    checks++;
    if ({CLKN_O, D_O, BUSY, DONE} !== 4'b1000) begin
      errors++;
      $display("FAIL rmid_abort got %b exp 1000", {CLKN_O, D_O, BUSY, DONE});
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (DONE || !CLKN_O || BUSY) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rmid_quiet got %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_random();
    logic [15:0] p;
    logic [3:0] l, dv, su;
    int D, L, qm, pa;
    for (int r = 0; r < 10; r++) begin
      p = 16'($urandom);
      l = 4'($urandom);
      dv = 4'($urandom_range(0, 4));
      D = (dv == 0) ? 1 : int'(dv);
      L = (l == 0) ? 16 : int'(l);
      su = 4'($urandom_range(0, D + 3));
      qm = int'($urandom_range(0, 1));
      if (su == 0) qm = 1;
      pa = int'($urandom_range(0, 2 * D * L + 1));
      run(p, l, dv, su, qm, pa, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_force0();
    test_len0_div0();
    test_setup_clamp();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
